// File: rtl/simple_out_uart.sv
// OUT-instruction UART: queues 16-bit OUT words in a small FIFO and sends each
// as two 8N1 frames (high byte first), stalling the core while the FIFO is full.
module simple_out_uart #(
   parameter int DATA_W       = 16,
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              out_valid,
   input  logic [DATA_W-1:0] out_data,
   output logic              stall,
   output logic              txd,
   output logic              tx_busy,
   output logic              ovf_err
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int BIT_W = $clog2(CLKS_PER_BIT);
   localparam int BYTE_W = DATA_W / 2;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [BIT_W-1:0] LAST_TICK = BIT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_next;

   state_t            state;
   logic [BIT_W-1:0]  bit_cnt;
   logic [2:0]        bit_idx;
   logic [BYTE_W-1:0] shreg;
   logic [BYTE_W-1:0] low_byte;
   logic              low_phase;

   logic              pop;
   logic              push;
   logic              bit_end;
   logic [DATA_W-1:0] head;

   // A pop frees a slot on the same edge, so a push into a full FIFO still lands
   assign pop     = (state == IDLE) && (count != '0);
   assign push    = out_valid && ((count != FULL_CNT) || pop);
   assign bit_end = (bit_cnt == LAST_TICK);
   assign head    = fifo_mem[rd_ptr];

   always_comb begin
      count_next = count;
      if (push && !pop)
         count_next = count + CNT_W'(1);
      else if (!push && pop)
         count_next = count - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr] <= out_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         stall   <= 1'b0;
         ovf_err <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count_next;
         stall <= (count_next == FULL_CNT);
         if (out_valid && !push)
            ovf_err <= 1'b1;
      end
   end

   // The high-byte STOP chains straight into the low-byte START; only the
   // low-byte STOP returns to IDLE, which yields the one idle cycle per word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         low_byte  <= '0;
         low_phase <= 1'b0;
         txd       <= 1'b1;
         tx_busy   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  shreg     <= head[DATA_W-1:BYTE_W];
                  low_byte  <= head[BYTE_W-1:0];
                  low_phase <= 1'b0;
                  bit_cnt   <= '0;
                  txd       <= 1'b0;
                  tx_busy   <= 1'b1;
                  state     <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  bit_idx <= '0;
                  txd     <= shreg[0];
                  state   <= DATA;
               end else begin
                  bit_cnt <= bit_cnt + BIT_W'(1);
               end
            end
            DATA: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     txd   <= 1'b1;
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     shreg   <= {1'b0, shreg[BYTE_W-1:1]};
                     txd     <= shreg[1];
                  end
               end else begin
                  bit_cnt <= bit_cnt + BIT_W'(1);
               end
            end
            STOP: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  if (!low_phase) begin
                     shreg     <= low_byte;
                     low_phase <= 1'b1;
                     txd       <= 1'b0;
                     state     <= START;
                  end else begin
                     tx_busy <= 1'b0;
                     state   <= IDLE;
                  end
               end else begin
                  bit_cnt <= bit_cnt + BIT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               txd   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_simple_out_uart.sv
// Bench for simple_out_uart: a queue-based model predicts the txd bit schedule,
// stall and overflow; outputs are compared against it on every falling edge.
module tb_simple_out_uart;

   localparam int CPB      = 4;
   localparam int DEPTH    = 4;
   localparam int WORD_CYC = 20 * CPB;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        out_valid = 1'b0;
   logic [15:0] out_data = 16'h0000;
   logic        stall;
   logic        txd;
   logic        tx_busy;
   logic        ovf_err;

   int tests_run = 0;
   int tests_failed = 0;

   simple_out_uart #(.DATA_W(16), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk),
      .rst(rst),
      .out_valid(out_valid),
      .out_data(out_data),
      .stall(stall),
      .txd(txd),
      .tx_busy(tx_busy),
      .ovf_err(ovf_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Behavioural model: queue of words plus position within the 20-bit word on the wire
   logic [15:0] m_q[$];
   logic [15:0] m_cur = 16'h0000;
   bit          m_active = 1'b0;
   int          m_pos = 0;
   bit          m_ovf = 1'b0;
   bit          m_stall = 1'b0;
   int          m_pops = 0;
   bit          m_pop;
   bit          m_accept;

   function automatic logic wire_bit(input logic [15:0] w, input int b);
      if (b == 0 || b == 10) return 1'b0;
      if (b == 9 || b == 19) return 1'b1;
      if (b < 9) return w[7 + b];
      return w[b - 11];
   endfunction

   function automatic logic exp_txd();
      if (!m_active) return 1'b1;
      return wire_bit(m_cur, m_pos / CPB);
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_q.delete();
         m_active = 1'b0;
         m_pos    = 0;
         m_ovf    = 1'b0;
         m_stall  = 1'b0;
      end else begin
         m_pop    = !m_active && (m_q.size() > 0);
         m_accept = out_valid && ((m_q.size() < DEPTH) || m_pop);
         if (m_pop) begin
            m_cur    = m_q.pop_front();
            m_active = 1'b1;
            m_pos    = 0;
            m_pops++;
         end else if (m_active) begin
            m_pos++;
            if (m_pos == WORD_CYC) m_active = 1'b0;
         end
         if (m_accept) m_q.push_back(out_data);
         else if (out_valid) m_ovf = 1'b1;
         m_stall = (m_q.size() == DEPTH);
      end
   end

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      checkOutput("txd", {15'd0, txd}, {15'd0, exp_txd()});
      checkOutput("tx_busy", {15'd0, tx_busy}, {15'd0, m_active});
      checkOutput("stall", {15'd0, stall}, {15'd0, m_stall});
      checkOutput("ovf_err", {15'd0, ovf_err}, {15'd0, m_ovf});
   end

   task automatic applyStimulus(input logic v, input logic [15:0] d);
      @(posedge clk);
      #1;
      out_valid = v;
      out_data  = d;
   endtask

   task automatic waitIdle(input string name);
      bit done = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk);
         #1;
         if (!m_active && m_q.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL %s: got still busy expected idle within bound", name);
      end
   endtask

   task automatic waitRoom(input int limit);
      bit done = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk);
         #1;
         if (m_q.size() < limit) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL wrap_room: got queue %0d expected below %0d", m_q.size(), limit);
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_txd"}, {15'd0, txd}, 16'd1);
      checkOutput({tag, "_stall"}, {15'd0, stall}, 16'd0);
      checkOutput({tag, "_busy"}, {15'd0, tx_busy}, 16'd0);
      checkOutput({tag, "_ovf"}, {15'd0, ovf_err}, 16'd0);
   endtask

   int pat [20] = '{0,1,0,1,0,0,1,0,1,1, 0,0,1,0,1,1,0,1,0,1};

   initial begin
      int pops_before;
      bit found;

      // Reset state
      @(negedge clk);
      checkResetOutputs("init");
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);

      // Pin the model's bit schedule against the hand-derived A55A pattern
      for (int i = 0; i < 20; i++)
         checkOutput("model_bit", {15'd0, wire_bit(16'hA55A, i)}, 16'(pat[i]));

      // Single word: txd falls one edge after the write edge, busy for 80 cycles
      applyStimulus(1'b1, 16'hA55A);
      applyStimulus(1'b0, 16'h0000);
      @(negedge clk);
      checkOutput("single_pre_txd", {15'd0, txd}, 16'd1);
      for (int k = 0; k < WORD_CYC; k++) begin
         @(negedge clk);
         checkOutput("single_txd", {15'd0, txd}, 16'(pat[k / CPB]));
         checkOutput("single_busy", {15'd0, tx_busy}, 16'd1);
      end
      @(negedge clk);
      checkOutput("single_post_busy", {15'd0, tx_busy}, 16'd0);

      // Fill/stall then overflow with DEAD
      waitIdle("single_drain");
      for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 16'(i));
      applyStimulus(1'b0, 16'h0000);
      @(negedge clk);
      checkOutput("fill_stall", {15'd0, stall}, 16'd1);
      applyStimulus(1'b1, 16'hDEAD);
      applyStimulus(1'b0, 16'h0000);
      @(negedge clk);
      checkOutput("ovf_set", {15'd0, ovf_err}, 16'd1);
      waitIdle("fill_drain");
      checkOutput("ovf_sticky", {15'd0, ovf_err}, 16'd1);

      // Reset mid-activity
      applyStimulus(1'b1, 16'h1234);
      applyStimulus(1'b0, 16'h0000);
      repeat (30) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkResetOutputs("rst_assert");
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      checkResetOutputs("rst_release");

      // Simultaneous push/pop while full
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'h2000 + 16'(i));
      applyStimulus(1'b0, 16'h0000);
      found = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(posedge clk);
         #1;
         if (!m_active && m_q.size() == DEPTH) begin
            found = 1'b1;
            break;
         end
      end
      checkOutput("pp_found_pop_edge", {15'd0, found}, 16'd1);
      out_valid = 1'b1;
      out_data  = 16'hBEEF;
      @(posedge clk);
      #1 out_valid = 1'b0;
      @(negedge clk);
      checkOutput("pp_ovf", {15'd0, ovf_err}, 16'd0);
      checkOutput("pp_stall", {15'd0, stall}, 16'd1);
      checkOutput("pp_count", 16'(m_q.size()), 16'd4);
      waitIdle("pp_drain");

      // Wrap-around: 12 words with gaps, never filling the FIFO
      pops_before = m_pops;
      for (int i = 0; i < 12; i++) begin
         waitRoom(DEPTH - 1);
         repeat ($urandom_range(1, 60)) @(posedge clk);
         applyStimulus(1'b1, 16'h1000 + 16'(i));
         applyStimulus(1'b0, 16'h0000);
      end
      waitIdle("wrap_drain");
      checkOutput("wrap_pops", 16'(m_pops - pops_before), 16'd12);
      checkOutput("wrap_ovf", {15'd0, ovf_err}, 16'd0);

      // Randomized traffic, including pushes that may hit a full FIFO
      for (int i = 0; i < 1500; i++)
         applyStimulus($urandom_range(0, 39) == 0, 16'($urandom));
      applyStimulus(1'b0, 16'h0000);
      waitIdle("random_drain");
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
